// File: rtl/ps2_key_event_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_event_decoder_if
// Purpose : bundles the scan-byte input strobe and the key-event ready/valid
//           stream of the PS/2 key event decoder.
// Signals : scan_code[7:0], scan_valid   -- byte receiver -> decoder
//           ev_valid, ev_key[5:0], ev_make -- decoder -> consumer (FIFO head)
//           ev_ready                      -- consumer -> decoder (pop)
// Modports: master -- the decoder (consumes scan bytes, produces events)
//           slave  -- the surrounding system (byte receiver + event consumer)
// ---------------------------------------------------------------------------
interface ps2_key_event_decoder_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       ev_valid;
  logic       ev_ready;
  logic [5:0] ev_key;
  logic       ev_make;

  modport master (
    input  scan_code, scan_valid, ev_ready,
    output ev_valid, ev_key, ev_make
  );

  modport slave (
    output scan_code, scan_valid, ev_ready,
    input  ev_valid, ev_key, ev_make
  );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_event_decoder
// Purpose : turns PS/2 set-2 scan bytes into make/break events for the keys
//           0-9, a-z and Enter, tracks E0/F0 prefixes, keeps a held-key
//           bitmap, optionally filters typematic repeats and queues events in
//           a small first-word-fall-through FIFO with a registered head.
// Ports   : clk, rst_n        clock / asynchronous active-low reset
//           bus (master)      scan_code/scan_valid in, ev_valid/ev_key/ev_make
//                             out, ev_ready in
//           clr_ovf           clears the sticky overflow flag
//           key_down[36:0]    held-key bitmap (bit i = key index i)
//           any_down          OR of key_down
//           fifo_count        number of queued events
//           overflow          sticky: an event was dropped on a full FIFO
// Key index: 0-9 digits, 10-35 letters a-z, 36 Enter.
// ---------------------------------------------------------------------------
module ps2_key_event_decoder #(
  parameter int FIFO_DEPTH    = 4,
  parameter bit REPEAT_FILTER = 1'b1,
  parameter int TIMEOUT_CYC   = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ps2_key_event_decoder_if.master     bus,
  input  logic                        clr_ovf,
  output logic [36:0]                 key_down,
  output logic                        any_down,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  // Scan code -> {hit, key index}. Unmapped codes (including E0/F0) miss.
  function automatic logic [6:0] decode_key(input logic [7:0] code);
    logic [6:0] r;
    case (code)
      8'h45: r = {1'b1, 6'd0};   8'h16: r = {1'b1, 6'd1};
      8'h1E: r = {1'b1, 6'd2};   8'h26: r = {1'b1, 6'd3};
      8'h25: r = {1'b1, 6'd4};   8'h2E: r = {1'b1, 6'd5};
      8'h36: r = {1'b1, 6'd6};   8'h3D: r = {1'b1, 6'd7};
      8'h3E: r = {1'b1, 6'd8};   8'h46: r = {1'b1, 6'd9};
      8'h1C: r = {1'b1, 6'd10};  8'h32: r = {1'b1, 6'd11};
      8'h21: r = {1'b1, 6'd12};  8'h23: r = {1'b1, 6'd13};
      8'h24: r = {1'b1, 6'd14};  8'h2B: r = {1'b1, 6'd15};
      8'h34: r = {1'b1, 6'd16};  8'h33: r = {1'b1, 6'd17};
      8'h43: r = {1'b1, 6'd18};  8'h3B: r = {1'b1, 6'd19};
      8'h42: r = {1'b1, 6'd20};  8'h4B: r = {1'b1, 6'd21};
      8'h3A: r = {1'b1, 6'd22};  8'h31: r = {1'b1, 6'd23};
      8'h44: r = {1'b1, 6'd24};  8'h4D: r = {1'b1, 6'd25};
      8'h15: r = {1'b1, 6'd26};  8'h2D: r = {1'b1, 6'd27};
      8'h1B: r = {1'b1, 6'd28};  8'h2C: r = {1'b1, 6'd29};
      8'h3C: r = {1'b1, 6'd30};  8'h2A: r = {1'b1, 6'd31};
      8'h1D: r = {1'b1, 6'd32};  8'h22: r = {1'b1, 6'd33};
      8'h35: r = {1'b1, 6'd34};  8'h1A: r = {1'b1, 6'd35};
      8'h5A: r = {1'b1, 6'd36};
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  // Registered state
  state_t          state_q, state_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [36:0]     key_down_q, key_down_d;
  logic            any_down_q, any_down_d;
  logic [6:0]      mem_q [FIFO_DEPTH];
  logic [6:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            ev_valid_q, ev_valid_d;
  logic [6:0]      head_q, head_d;

  // Combinational intermediates
  logic            key_req;
  logic            key_make;
  logic [7:0]      key_code;
  logic [6:0]      map_s;
  logic            push_req;
  logic            pop;
  logic            full;
  logic            push_ok;
  logic            drop;

  // Prefix FSM and timeout counter: decides which byte is a make/break request.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    key_req  = 1'b0;
    key_make = 1'b0;
    key_code = 8'h00;
    if (bus.scan_valid) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.scan_code == 8'hE0) begin
            state_d = ST_EXT;
          end else if (bus.scan_code == 8'hF0) begin
            state_d = ST_BRK;
          end else begin
            key_req  = 1'b1;
            key_make = 1'b1;
            key_code = bus.scan_code;
          end
        end
        ST_EXT: begin
          if (bus.scan_code == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else if (bus.scan_code == 8'h5A) begin
            key_req  = 1'b1;
            key_make = 1'b1;
            key_code = 8'h5A;
            state_d  = ST_IDLE;
          end else begin
            // Only Enter is mapped in the extended page.
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          // E0/F0 land here as unmapped codes and simply drop the prefix.
          key_req  = 1'b1;
          key_code = bus.scan_code;
          state_d  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          if (bus.scan_code == 8'h5A) begin
            key_req  = 1'b1;
            key_code = 8'h5A;
          end else begin
            key_req  = 1'b0;
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      // A stale prefix is abandoned after TIMEOUT_CYC quiet clocks.
      if (to_cnt_q == TO_LAST) begin
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Bitmap update and event generation from a decoded make/break request.
  always_comb begin
    map_s      = decode_key(key_code);
    key_down_d = key_down_q;
    push_req   = 1'b0;
    if (key_req && map_s[6]) begin
      if (key_make) begin
        if (!key_down_q[map_s[5:0]]) begin
          key_down_d[map_s[5:0]] = 1'b1;
          push_req               = 1'b1;
        end else begin
          // Typematic repeat of a key that is already held.
          push_req = !REPEAT_FILTER;
        end
      end else begin
        if (key_down_q[map_s[5:0]]) begin
          key_down_d[map_s[5:0]] = 1'b0;
          push_req               = 1'b1;
        end else begin
          push_req = 1'b0;
        end
      end
    end else begin
      push_req = 1'b0;
    end
    any_down_d = |key_down_d;
  end

  // Event FIFO: push/pop bookkeeping, overflow flag and registered head.
  always_comb begin
    pop        = ev_valid_q && bus.ev_ready;
    full       = (count_q == CNT_FULL);
    // A same-cycle pop frees the slot even when full.
    push_ok    = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    head_d     = head_q;
    ev_valid_d = 1'b0;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {map_s[5:0], key_make};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as clr_ovf keeps the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    // The head register follows the next oldest entry; when the FIFO
    // drains it keeps the last event so ev_key/ev_make hold steady.
    if (count_d != '0) begin
      head_d     = mem_d[rd_ptr_d];
      ev_valid_d = 1'b1;
    end else begin
      head_d     = head_q;
      ev_valid_d = 1'b0;
    end
  end

  // State register for FSM, timeout, bitmap and FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      to_cnt_q   <= '0;
      key_down_q <= '0;
      any_down_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ev_valid_q <= 1'b0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      key_down_q <= key_down_d;
      any_down_q <= any_down_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      ev_valid_q <= ev_valid_d;
      head_q     <= head_d;
    end
  end

  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_key   = head_q[6:1];
  assign bus.ev_make  = head_q[0];
  assign key_down     = key_down_q;
  assign any_down     = any_down_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_event_decoder
// Self-checking bench: directed scenarios followed by random byte traffic,
// all compared each cycle against a behavioural model built from the key
// map table, prefix flags, a held-key bit vector and an event queue.
// ---------------------------------------------------------------------------
module tb_ps2_key_event_decoder;

  localparam int DEPTH = 4;
  localparam bit RF    = 1'b1;
  localparam int TO    = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [36:0] key_down;
  logic        any_down;
  logic [2:0]  fifo_count;
  logic        overflow;

  ps2_key_event_decoder_if bus();

  ps2_key_event_decoder #(
    .FIFO_DEPTH   (DEPTH),
    .REPEAT_FILTER(RF),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_ovf   (clr_ovf),
    .key_down  (key_down),
    .any_down  (any_down),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Scan code for key index i.
  logic [7:0] keymap [37] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h5A
  };

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bit rdy_g = 1'b0;
  bit clr_g = 1'b0;

  // Model state
  bit          m_ext, m_brk;
  int          m_idle;
  bit   [36:0] m_held;
  logic [6:0]  m_q [$];
  logic [6:0]  m_last;
  bit          m_ovf;

  // Events actually handed over by the DUT ({key, make})
  logic [6:0]  log_q [$];

  function automatic int lookup(input logic [7:0] c);
    for (int i = 0; i < 37; i++) begin
      if (keymap[i] == c) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_idle = 0;
    m_held = '0; m_q.delete(); m_last = '0; m_ovf = 1'b0;
  endtask

  // One clock of the reference behaviour, using the inputs about to be sampled.
  task automatic model_cycle(input bit sv, input logic [7:0] code);
    int k;
    bit mk, push, pop, drop;
    k = -1; mk = 1'b0; push = 1'b0; drop = 1'b0;
    pop = (m_q.size() != 0) && rdy_g;
    if (sv) begin
      m_idle = 0;
      if (!m_ext && !m_brk) begin
        if (code == 8'hE0) m_ext = 1'b1;
        else if (code == 8'hF0) m_brk = 1'b1;
        else begin k = lookup(code); mk = 1'b1; end
      end else if (m_ext && !m_brk) begin
        if (code == 8'hF0) m_brk = 1'b1;
        else begin
          if (code == 8'h5A) begin k = 36; mk = 1'b1; end
          m_ext = 1'b0;
        end
      end else if (!m_ext && m_brk) begin
        k = lookup(code); mk = 1'b0; m_brk = 1'b0;
      end else begin
        if (code == 8'h5A) k = 36;
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle >= TO) begin m_ext = 1'b0; m_brk = 1'b0; m_idle = 0; end
    end
    if (k >= 0) begin
      if (mk) begin
        if (!m_held[k]) begin m_held[k] = 1'b1; push = 1'b1; end
        else push = !RF;
      end else if (m_held[k]) begin
        m_held[k] = 1'b0; push = 1'b1;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back({6'(k), mk});
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_g) m_ovf = 1'b0;
    if (m_q.size() != 0) m_last = m_q[0];
  endtask

  task automatic check_all();
    chk("ev_valid",   64'(bus.ev_valid), 64'(m_q.size() != 0));
    chk("ev_key",     64'(bus.ev_key),   64'(m_last[6:1]));
    chk("ev_make",    64'(bus.ev_make),  64'(m_last[0]));
    chk("key_down",   64'(key_down),     64'(m_held));
    chk("any_down",   64'(any_down),     64'(|m_held));
    chk("fifo_count", 64'(fifo_count),   64'(m_q.size()));
    chk("overflow",   64'(overflow),     64'(m_ovf));
  endtask

  // Drive one cycle at the falling edge, check just after the rising edge.
  task automatic step(input bit sv, input logic [7:0] code);
    @(negedge clk);
    bus.scan_valid = sv;
    bus.scan_code  = code;
    bus.ev_ready   = rdy_g;
    clr_ovf        = clr_g;
    if (bus.ev_valid && bus.ev_ready) log_q.push_back({bus.ev_key, bus.ev_make});
    model_cycle(sv, code);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] code);
    step(1'b1, code);
  endtask

  initial begin
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    bus.ev_ready   = 1'b0;
    model_reset();

    // Reset state
    #1;
    check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: make then break of 'a'
    rdy_g = 1'b1;
    log_q.delete();
    send(8'h1C);
    chk("t1_down_set", 64'(key_down[10]), 64'd1);
    send(8'hF0); send(8'h1C);
    chk("t1_down_clr", 64'(key_down[10]), 64'd0);
    idle(3);
    chk("t1_n",  64'(log_q.size()), 64'd2);
    chk("t1_e0", 64'(log_q[0]), 64'({6'd10, 1'b1}));
    chk("t1_e1", 64'(log_q[1]), 64'({6'd10, 1'b0}));

    // 2: repeats filtered
    log_q.delete();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    idle(3);
    chk("t2_n",  64'(log_q.size()), 64'd2);
    chk("t2_e0", 64'(log_q[0]), 64'({6'd10, 1'b1}));
    chk("t2_e1", 64'(log_q[1]), 64'({6'd10, 1'b0}));

    // 3: extended Enter, unmapped extended code, then a plain key
    log_q.delete();
    send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A);
    send(8'hE0); send(8'h75); send(8'h1C);
    idle(3);
    chk("t3_n",  64'(log_q.size()), 64'd3);
    chk("t3_e0", 64'(log_q[0]), 64'({6'd36, 1'b1}));
    chk("t3_e1", 64'(log_q[1]), 64'({6'd36, 1'b0}));
    chk("t3_e2", 64'(log_q[2]), 64'({6'd10, 1'b1}));
    send(8'hF0); send(8'h1C);
    idle(2);

    // 4: overflow with consumer stalled
    rdy_g = 1'b0;
    send(8'h45); send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    chk("t4_count", 64'(fifo_count), 64'd4);
    chk("t4_ovf",   64'(overflow), 64'd1);
    chk("t4_down",  64'(key_down[5:0]), 64'h3F);
    log_q.delete();
    rdy_g = 1'b1;
    idle(4);
    chk("t4_n", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("t4_head", 64'(log_q[i]), 64'({6'(i), 1'b1}));
    chk("t4_ovf_held", 64'(overflow), 64'd1);
    clr_g = 1'b1; idle(1); clr_g = 1'b0;
    chk("t4_ovf_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 6; i++) begin send(8'hF0); send(keymap[i]); end
    idle(2);

    // 5: prefix timeout, and the cycle just short of it
    send(8'hF0); idle(TO);
    log_q.delete();
    send(8'h1C); idle(2);
    chk("t5_n",  64'(log_q.size()), 64'd1);
    chk("t5_e0", 64'(log_q[0]), 64'({6'd10, 1'b1}));
    send(8'hF0); idle(TO - 1);
    log_q.delete();
    send(8'h1C); idle(2);
    chk("t5b_n",  64'(log_q.size()), 64'd1);
    chk("t5b_e0", 64'(log_q[0]), 64'({6'd10, 1'b0}));

    // 6: reset in the middle of a break sequence with keys held and overflow set
    rdy_g = 1'b0;
    send(8'h1C); send(8'h32); send(8'h21); send(8'h3B); send(8'h42); send(8'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.scan_valid = 1'b0;
    #1;
    model_reset();
    chk("t6_down",  64'(key_down), 64'd0);
    chk("t6_valid", 64'(bus.ev_valid), 64'd0);
    chk("t6_count", 64'(fifo_count), 64'd0);
    chk("t6_ovf",   64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_g = 1'b1;
    send(8'h1C);
    chk("t6_make_after", 64'(key_down[10]), 64'd1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [7:0] code;
      rdy_g = ($urandom_range(0, 3) != 0);
      clr_g = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 9);
      case (r)
        0:       code = 8'hE0;
        1:       code = 8'hF0;
        2:       code = 8'h5A;
        3:       code = 8'($urandom_range(0, 255));
        default: code = keymap[$urandom_range(0, 36)];
      endcase
      if ($urandom_range(0, 59) == 0) idle(TO - 2 + $urandom_range(0, 3));
      else step($urandom_range(0, 2) == 0, code);
    end
    clr_g = 1'b0;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
